// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: 2-flop synchroniser, stable-time counter, debounced level and press/release pulses.
// Optional long-press pulse per channel when KEY_LONG_PRESS_EN is defined; otherwise long_flag is tied low.
module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int CNT_MAX    = 1_000_000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int LONG_MAX   = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_value,
  output logic [N_KEYS-1:0] flag,
  output logic [N_KEYS-1:0] rel_flag,
  output logic [N_KEYS-1:0] long_flag
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [N_KEYS-1:0] POLARITY = {N_KEYS{ACTIVE_LOW}};

  if (N_KEYS < 1 || CNT_MAX < 2 || LONG_MAX <= CNT_MAX) begin : g_param_check
    $error("key_debounce_multi: invalid parameter combination");
  end

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [CW-1:0]     cnt [N_KEYS];

  // Synchroniser holds polarity-normalised samples, so reset value 0 is the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key ^ POLARITY;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_value <= '0;
      flag      <= '0;
      rel_flag  <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      flag     <= '0;
      rel_flag <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync2[i] == key_value[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          key_value[i] <= sync2[i];
          cnt[i]       <= '0;
          flag[i]      <= sync2[i];
          rel_flag[i]  <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_MAX - 1);
  localparam logic [HW-1:0] HOLD_SPENT = HW'(LONG_MAX);

  logic [HW-1:0] hcnt [N_KEYS];

  // HOLD_SPENT parks the counter after the pulse so it fires only once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_flag <= '0;
      for (int i = 0; i < N_KEYS; i++) hcnt[i] <= '0;
    end else begin
      long_flag <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (!key_value[i]) begin
          hcnt[i] <= '0;
        end else if (hcnt[i] < HOLD_LAST) begin
          hcnt[i] <= hcnt[i] + HW'(1);
        end else if (hcnt[i] == HOLD_LAST) begin
          long_flag[i] <= 1'b1;
          hcnt[i]      <= HOLD_SPENT;
        end
      end
    end
  end
`else
  assign long_flag = '0;
`endif

endmodule
